leaf_out_rr_arbiter: RTL and testbench

//  Shares one leaf_interface output port (din/vld/ack) among NUM_REQ HLS operator output streams.

---
 rtl/leaf_arb_pkg.sv | 29 ++
 rtl/leaf_arb_out_reg.sv | 35 +++
 rtl/leaf_out_rr_arbiter.sv | 105 ++++++++++
 tb/tb_leaf_out_rr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_arb_pkg.sv
// Shared types and the round-robin pick used by the leaf output arbiter.
package leaf_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BURST} arb_state_t;

  localparam int unsigned MAX_REQ  = 32;
  localparam int unsigned IDX_BITS = $clog2(MAX_REQ);

  // First valid index after 'last', wrapping at n; returns 'last' when nothing is valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = last + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i <= n) && valid[idx[IDX_BITS-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/leaf_arb_out_reg.sv
// One-entry AXI-stream register: 1 cycle latency, full throughput.
// Backpressure: in_ready = !out_valid || out_ready, contents hold while stalled.
module leaf_arb_out_reg #(
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/leaf_out_rr_arbiter.sv
// Round-robin, burst-bounded arbiter of NUM_REQ streams onto one leaf output port.
// Latency: accept to out_TVALID 1 cycle; stalls hold the output and drop all req_TREADY.
module leaf_out_rr_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 32,
  parameter int MAX_BURST = 16,
  parameter int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_TDATA,
  input  logic [NUM_REQ-1:0]           req_TVALID,
  output logic [NUM_REQ-1:0]           req_TREADY,
  output logic [DATA_BITS-1:0]         out_TDATA,
  output logic                         out_TVALID,
  input  logic                         out_TREADY,
  output logic [ID_BITS-1:0]           out_id,
  output logic                         busy
);

  localparam int                   CNT_BITS = $clog2(MAX_BURST);
  localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(MAX_BURST - 1);
  localparam logic [ID_BITS-1:0]   ID_LAST  = ID_BITS'(NUM_REQ - 1);

  arb_state_t                   state_q;
  logic [ID_BITS-1:0]           grant_q;
  logic [ID_BITS-1:0]           last_grant_q;
  logic [CNT_BITS-1:0]          burst_cnt_q;

  logic [ID_BITS-1:0]           pick;
  logic                         slot_free;
  logic                         grant_vld;
  logic                         grant_rdy;
  logic                         accept;
  logic [DATA_BITS-1:0]         grant_dat;
  logic [ID_BITS+DATA_BITS-1:0] reg_out;

  always_comb begin
    pick = ID_BITS'(rr_pick(MAX_REQ'(req_TVALID), 32'(last_grant_q), NUM_REQ));
  end

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_BITS'(i)) grant_dat = req_TDATA[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign grant_vld = req_TVALID[grant_q];
  assign grant_rdy = (state_q == ST_BURST) && slot_free;
  assign accept    = grant_rdy && grant_vld;

  always_comb begin
    req_TREADY          = '0;
    req_TREADY[grant_q] = grant_rdy;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_LAST;
      burst_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_TVALID) begin
            grant_q     <= pick;
            burst_cnt_q <= '0;
            state_q     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) burst_cnt_q <= burst_cnt_q + CNT_BITS'(1);
          // Rotate on a full burst, or when the granted stream has nothing while space is free.
          if ((accept && (burst_cnt_q == CNT_LAST)) || (grant_rdy && !grant_vld)) begin
            state_q      <= ST_IDLE;
            last_grant_q <= grant_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  leaf_arb_out_reg #(
    .WIDTH(ID_BITS + DATA_BITS)
  ) u_out_reg (
    .clk_i    (ap_clk),
    .rst_ni   (ap_rst_n),
    .in_valid (accept),
    .in_ready (slot_free),
    .in_data  ({grant_q, grant_dat}),
    .out_valid(out_TVALID),
    .out_ready(out_TREADY),
    .out_data (reg_out)
  );

  assign out_id    = reg_out[ID_BITS+DATA_BITS-1 -: ID_BITS];
  assign out_TDATA = reg_out[DATA_BITS-1:0];
  assign busy      = (state_q == ST_BURST) || out_TVALID;

endmodule

// File: tb/tb_leaf_out_rr_arbiter.sv
// Bench for leaf_out_rr_arbiter: directed vector table, burst/stall/reset sequences, random traffic.
module tb_leaf_out_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int IW = 2;
  localparam int FAIR_MAX = (NR + 1) * (MB + 2);

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic [NR*DW-1:0] req_TDATA = '0;
  logic [NR-1:0]    req_TVALID = '0;
  logic [NR-1:0]    req_TREADY;
  logic [DW-1:0]    out_TDATA;
  logic             out_TVALID;
  logic             out_TREADY = 1'b0;
  logic [IW-1:0]    out_id;
  logic             busy;

  int checks = 0;
  int failures = 0;

  // Source controls: mode 0 off, 1 always valid, 2 random (held until accepted), 3 counted beats.
  int            mode[NR];
  int            seq[NR];
  int            cnt[NR];
  int            wait_c[NR];
  logic [NR-1:0] hs = '0;
  logic [NR-1:0] pend = '0;
  logic          rst_n_n = 1'b0;
  logic          ordy_n = 1'b1;
  logic          direct = 1'b0;
  logic [NR-1:0] dir_vld = '0;
  logic [DW-1:0] dir_dat = '0;
  int            beats = 0;

  logic [IW+DW-1:0] sb_q[$];

  typedef struct {
    logic [NR-1:0] vld;
    logic [DW-1:0] dat;
    logic          ordy;
    logic [NR-1:0] e_trdy;
    logic          e_ovld;
    logic [DW-1:0] e_odat;
    logic [IW-1:0] e_oid;
    logic          e_busy;
  } vec_t;

  vec_t tbl[8];

  always #5 ap_clk = ~ap_clk;

  leaf_out_rr_arbiter #(
    .NUM_REQ  (NR),
    .DATA_BITS(DW),
    .MAX_BURST(MB),
    .ID_BITS  (IW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_TDATA (req_TDATA),
    .req_TVALID(req_TVALID),
    .req_TREADY(req_TREADY),
    .out_TDATA (out_TDATA),
    .out_TVALID(out_TVALID),
    .out_TREADY(out_TREADY),
    .out_id    (out_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic advance();
    for (int i = 0; i < NR; i++) begin
      pend[i] = req_TVALID[i] && !hs[i];
      if (hs[i]) begin
        seq[i]++;
        if (cnt[i] > 0) cnt[i]--;
      end
    end
    hs = '0;
  endtask

  task automatic apply();
    ap_rst_n   = rst_n_n;
    out_TREADY = ordy_n;
    for (int i = 0; i < NR; i++) begin
      logic v;
      if (direct) begin
        v = dir_vld[i];
        req_TDATA[i*DW +: DW] = dir_dat;
      end else begin
        case (mode[i])
          1:       v = 1'b1;
          2:       v = pend[i] || ($urandom_range(0, 3) != 0);
          3:       v = (cnt[i] > 0);
          default: v = 1'b0;
        endcase
        req_TDATA[i*DW +: DW] = {8'(i), 8'h5A, 16'(seq[i])};
      end
      req_TVALID[i] = v;
    end
  endtask

  // Scoreboard: the queue mirrors what the output register must hold, oldest beat first.
  task automatic monitor();
    logic [NR-1:0] hsv;
    hsv = req_TVALID & req_TREADY;
    if (!ap_rst_n) begin
      sb_q.delete();
      hs = '0;
      for (int i = 0; i < NR; i++) wait_c[i] = 0;
      return;
    end
    chk("tready_onehot0", 64'($onehot0(req_TREADY)), 64'd1);
    chk("accept_while_full", 64'((|hsv) && out_TVALID && !out_TREADY), 64'd0);
    if (!direct) begin
      chk("out_vld", 64'(out_TVALID), 64'(sb_q.size() != 0));
      if (out_TVALID && (sb_q.size() != 0)) begin
        chk("out_beat", 64'({out_id, out_TDATA}), 64'(sb_q[0]));
        if (out_TREADY) begin
          void'(sb_q.pop_front());
          beats++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (hsv[i]) sb_q.push_back({IW'(i), req_TDATA[i*DW +: DW]});
        if (req_TVALID[i] && !hsv[i]) begin
          if (out_TREADY) wait_c[i]++;
          chk("fair_wait", 64'(wait_c[i] <= FAIR_MAX), 64'd1);
        end else begin
          wait_c[i] = 0;
        end
      end
    end
    hs = hsv;
  endtask

  task automatic cycle();
    @(posedge ap_clk);
    #1;
    advance();
    apply();
    @(negedge ap_clk);
    monitor();
  endtask

  task automatic do_reset();
    rst_n_n = 1'b0;
    cycle();
    cycle();
    chk("rst_out_vld", 64'(out_TVALID), 64'd0);
    chk("rst_out_dat", 64'(out_TDATA), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_tready", 64'(req_TREADY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] exp_t;
    logic          found;
    logic [NR-1:0] t4_exp[7];

    tbl[0] = '{4'b0100, 32'hA0, 1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 1'b0};
    tbl[1] = '{4'b0100, 32'hA0, 1'b1, 4'b0100, 1'b0, 32'h0,  2'd0, 1'b1};
    tbl[2] = '{4'b0100, 32'hA1, 1'b1, 4'b0100, 1'b1, 32'hA0, 2'd2, 1'b1};
    tbl[3] = '{4'b0100, 32'hA2, 1'b1, 4'b0100, 1'b1, 32'hA1, 2'd2, 1'b1};
    tbl[4] = '{4'b0100, 32'hA3, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2, 1'b1};
    tbl[5] = '{4'b0100, 32'hA4, 1'b1, 4'b0100, 1'b1, 32'hA3, 2'd2, 1'b1};
    tbl[6] = '{4'b0000, 32'h0,  1'b1, 4'b0100, 1'b1, 32'hA4, 2'd2, 1'b1};
    tbl[7] = '{4'b0000, 32'h0,  1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 1'b0};
    t4_exp = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000};

    for (int i = 0; i < NR; i++) begin
      mode[i] = 0; seq[i] = 0; cnt[i] = 0; wait_c[i] = 0;
    end

    do_reset();

    // Single requester, five beats, vector table.
    direct = 1'b1;
    for (int r = 0; r < 8; r++) begin
      dir_vld = tbl[r].vld;
      dir_dat = tbl[r].dat;
      ordy_n  = tbl[r].ordy;
      cycle();
      chk("t1_tready", 64'(req_TREADY), 64'(tbl[r].e_trdy));
      chk("t1_out_vld", 64'(out_TVALID), 64'(tbl[r].e_ovld));
      chk("t1_busy", 64'(busy), 64'(tbl[r].e_busy));
      if (tbl[r].e_ovld) begin
        chk("t1_out_dat", 64'(out_TDATA), 64'(tbl[r].e_odat));
        chk("t1_out_id", 64'(out_id), 64'(tbl[r].e_oid));
      end
    end
    direct = 1'b0;

    // All requesters saturated: 16-beat bursts in order 0,1,2,3,0 with one idle cycle between.
    do_reset();
    for (int i = 0; i < NR; i++) mode[i] = 1;
    for (int k = 0; k < 5 * (MB + 1); k++) begin
      cycle();
      exp_t = ((k % (MB + 1)) == 0) ? 4'b0000 : 4'(1 << ((k / (MB + 1)) % NR));
      chk("t2_grant", 64'(req_TREADY), 64'(exp_t));
    end

    // req1 alone, 10-cycle output stall in mid-stream.
    for (int i = 0; i < NR; i++) mode[i] = (i == 1) ? 1 : 0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cycle();
      if (req_TREADY == 4'b0010) found = 1'b1;
    end
    chk("t3_grant_seen", 64'(found), 64'd1);
    ordy_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t3_stall_vld", 64'(out_TVALID), 64'd1);
      chk("t3_stall_tready", 64'(req_TREADY[1]), 64'd0);
      if (sb_q.size() != 0) chk("t3_stall_id", 64'(out_id), 64'(sb_q[0][IW+DW-1 -: IW]));
    end
    ordy_n = 1'b1;
    for (int k = 0; k < 40; k++) cycle();

    // req0 sends 3 beats then goes quiet while req3 waits.
    do_reset();
    for (int i = 0; i < NR; i++) mode[i] = 0;
    mode[0] = 3; cnt[0] = 3; mode[3] = 1;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("t4_tready", 64'(req_TREADY), 64'(t4_exp[k]));
      if (k == 5) chk("t4_last_grant", 64'(dut.last_grant_q), 64'd0);
    end

    // One-cycle reset in mid-burst with a beat held in the output register.
    for (int i = 0; i < NR; i++) mode[i] = 1;
    for (int k = 0; k < 4; k++) cycle();
    chk("t5_pre_vld", 64'(out_TVALID), 64'd1);
    rst_n_n = 1'b0;
    cycle();
    rst_n_n = 1'b1;
    cycle();
    chk("t5_out_vld", 64'(out_TVALID), 64'd0);
    chk("t5_tready", 64'(req_TREADY), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    cycle();
    chk("t5_first_grant", 64'(req_TREADY), 64'd1);

    // Random traffic and random backpressure, then drain.
    beats = 0;
    for (int i = 0; i < NR; i++) mode[i] = 2;
    for (int k = 0; k < 3000; k++) begin
      ordy_n = ($urandom_range(0, 3) != 0);
      cycle();
    end
    chk("t6_progress", 64'(beats > 200), 64'd1);
    for (int i = 0; i < NR; i++) mode[i] = 0;
    ordy_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (!busy && (req_TVALID == '0) && (sb_q.size() == 0)) found = 1'b1;
    end
    chk("t6_drained", 64'(found), 64'd1);
    chk("t6_out_vld_end", 64'(out_TVALID), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
